// File: rtl/fir_sm_fifo_if.sv
// ---------------------------------------------------------------------------
// fir_sm_fifo_if
// AXI-Stream beat bundle used on both sides of the FIR output buffer.
//   tvalid : beat valid      (master -> slave)
//   tdata  : beat payload    (master -> slave), W bits
//   tlast  : end of frame    (master -> slave)
//   tready : sink can accept (slave  -> master)
// ---------------------------------------------------------------------------
interface fir_sm_fifo_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/fir_sm_fifo.sv
// ---------------------------------------------------------------------------
// fir_sm_fifo
// First-word-fall-through buffer behind the FIR stream master. It stores
// data plus tlast, reports exact occupancy, and counts beats per frame so
// firmware can compare the delivered frame length against data_len.
//   axis_clk   : clock
//   axis_rst_n : asynchronous active-low reset
//   clear      : synchronous flush of storage and counters (wins over push/pop)
//   s_axis     : slave stream from the FIR sm_* port (s_tready registered)
//   m_axis     : master stream to the consumer (all outputs registered)
//   level      : occupancy 0..DEPTH
//   beat_cnt   : beats popped in the current frame
//   frame_len  : beat count of the last completed frame
//   frame_done : one-cycle pulse after the pop of a tlast beat
// ---------------------------------------------------------------------------
module fir_sm_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              clear,
  fir_sm_fifo_if.slave      s_axis,
  fir_sm_fifo_if.master     m_axis,
  output logic [ADDR_W:0]   level,
  output logic [31:0]       beat_cnt,
  output logic [31:0]       frame_len,
  output logic              frame_done
);

  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ZERO_LVL = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

  // Storage entry: {tlast, tdata}
  logic [pDATA_WIDTH:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        level_q, level_d;
  logic                   s_tready_q, s_tready_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [pDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [31:0]            beat_cnt_q, beat_cnt_d;
  logic [31:0]            frame_len_q, frame_len_d;
  logic                   frame_done_q, frame_done_d;
  logic                   push_s, pop_s;
  logic [pDATA_WIDTH:0]   head_s;

  // Next-state computation for pointers, occupancy, output register and counters
  always_comb begin
    push_s       = s_axis.tvalid && s_tready_q;
    pop_s        = m_tvalid_q && m_axis.tready;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    s_tready_d   = s_tready_q;
    m_tvalid_d   = m_tvalid_q;
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = m_tlast_q;
    beat_cnt_d   = beat_cnt_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    head_s       = mem_q[rd_ptr_q];

    if (clear) begin
      // Flush; m_tdata/m_tlast keep their last values like any empty state
      wr_ptr_d    = PTR_ZERO;
      rd_ptr_d    = PTR_ZERO;
      level_d     = ZERO_LVL;
      s_tready_d  = 1'b1;
      m_tvalid_d  = 1'b0;
      beat_cnt_d  = 32'd0;
      frame_len_d = 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      level_d    = level_q + {PTR_ZERO, push_s} - {PTR_ZERO, pop_s};
      s_tready_d = (level_d < FULL_LVL);
      m_tvalid_d = (level_d != ZERO_LVL);

      // The next head is the incoming beat when it lands in the slot the
      // read pointer moves to (FIFO empty after this cycle's pop); otherwise
      // it is already in the array.
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
        head_s = {s_axis.tlast, s_axis.tdata};
      end else begin
        head_s = mem_q[rd_ptr_d];
      end
      if (level_d != ZERO_LVL) begin
        m_tdata_d = head_s[pDATA_WIDTH-1:0];
        m_tlast_d = head_s[pDATA_WIDTH];
      end else begin
        m_tdata_d = m_tdata_q;
        m_tlast_d = m_tlast_q;
      end

      if (pop_s && m_tlast_q) begin
        frame_len_d  = beat_cnt_q + 32'd1;
        beat_cnt_d   = 32'd0;
        frame_done_d = 1'b1;
      end else if (pop_s) begin
        beat_cnt_d   = beat_cnt_q + 32'd1;
      end else begin
        beat_cnt_d   = beat_cnt_q;
      end
    end
  end

  // Beat storage write port; contents need no reset since level gates reads
  always_ff @(posedge axis_clk) begin
    if (push_s && !clear) begin
      mem_q[wr_ptr_q] <= {s_axis.tlast, s_axis.tdata};
    end
  end

  // Control and output registers with asynchronous reset
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      level_q      <= ZERO_LVL;
      s_tready_q   <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= {pDATA_WIDTH{1'b0}};
      m_tlast_q    <= 1'b0;
      beat_cnt_q   <= 32'd0;
      frame_len_q  <= 32'd0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      s_tready_q   <= s_tready_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tlast_q    <= m_tlast_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_axis.tready = s_tready_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tlast  = m_tlast_q;
  assign level         = level_q;
  assign beat_cnt      = beat_cnt_q;
  assign frame_len     = frame_len_q;
  assign frame_done    = frame_done_q;

endmodule

// File: doc/fir_sm_fifo.md
Name: fir_sm_fifo

Overview:
- Output buffer placed directly downstream of the FIR AXI-Stream master port (sm_tvalid/sm_tdata/sm_tlast/sm_tready).
- Decouples the FIR core from a stalling consumer: first-word-fall-through FIFO carrying data plus the tlast flag.
- Reports per-frame output length and a frame-done pulse so firmware can cross-check against the programmed data_len.

Parameters:
pDATA_WIDTH, 32, stream data width
DEPTH, 8, FIFO entries; must be a power of 2, minimum 2
ADDR_W, 3, log2(DEPTH)

Ports:
axis_clk  input  1  clock
axis_rst_n  input  1  reset
clear  input  1  synchronous flush of FIFO and counters
s_tvalid  input  1  from FIR sm_tvalid
s_tdata  input  pDATA_WIDTH  from FIR sm_tdata
s_tlast  input  1  from FIR sm_tlast
s_tready  output  1  to FIR sm_tready
m_tvalid  output  1  to consumer
m_tdata  output  pDATA_WIDTH  to consumer
m_tlast  output  1  to consumer
m_tready  input  1  from consumer
level  output  ADDR_W+1  current occupancy, 0..DEPTH
beat_cnt  output  32  beats delivered in the current frame
frame_len  output  32  beat count of the last completed frame
frame_done  output  1  one-cycle pulse per completed frame

Behaviour:
- Reset: axis_rst_n is asynchronous, active-low; clock is axis_clk.
- Values in reset: pointers=0, level=0, s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, beat_cnt=0, frame_len=0, frame_done=0.
- The first cycle after reset release drives s_tready=1. s_tready is a registered version of (next level < DEPTH).
- Storage: DEPTH x (pDATA_WIDTH+1) array holding data and last. Write pointer and read pointer are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- Push occurs when s_tvalid && s_tready. Pop occurs when m_tvalid && m_tready.
- Full: level==DEPTH gives s_tready=0. A push is never accepted while full, even if a pop happens in the same cycle. s_tready rises the cycle after level drops.
- Empty: level==0 gives m_tvalid=0; m_tdata and m_tlast hold their last values.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both pointers advance.
- FWFT latency: a beat pushed in cycle N, with the FIFO empty, appears as m_tvalid=1 with its data at cycle N+1.
- Outputs are driven from registers or from the array indexed by the registered read pointer. There is no combinational path from s_* or m_tready to any output.
- AXIS compliance: once m_tvalid=1, m_tvalid, m_tdata and m_tlast stay stable until a pop occurs.
- beat_cnt increments on each pop.
- On a pop with m_tlast=1:
  - frame_len <= beat_cnt+1
  - beat_cnt <= 0
  - frame_done pulses 1 in the next cycle
- s_tlast is stored verbatim. A frame with no tlast simply keeps counting; beat_cnt wraps at 2^32.
- clear: a synchronous flush with priority over push and pop in the same cycle. It sets:
  - pointers=0, level=0
  - m_tvalid=0
  - beat_cnt=0, frame_len=0, frame_done=0
  - s_tready=1 on the following cycle
  A beat offered in the same cycle as clear is dropped.
- Asynchronous reset asserted mid-frame discards all stored beats immediately.
- level is exact in every cycle: level = pushes - pops since the last reset or clear.

Test Plan:
- Pass-through: push 0x11,0x22,0x33 (last on 0x33) with m_tready=1 -> m_tdata 0x11,0x22,0x33 on consecutive cycles, each one cycle after its push; frame_len=3; one frame_done pulse; level ≤1 throughout.
- Fill/backpressure: m_tready=0, push 10 beats 1..10 -> exactly 8 accepted, level=8, s_tready=0; then m_tready=1 -> 1..8 emerge in order, s_tready returns 1 one cycle after the first pop.
- Simultaneous push/pop at level=4 -> level stays 4 and data order is preserved across pointer wrap (push 20 beats continuously, random m_tready, sequence intact).
- Stability: m_tready toggled 0/1 randomly with a 64-beat frame -> m_tdata/m_tlast never change while m_tvalid && !m_tready; frame_len=64.
- clear with level=5 and s_tvalid=1 in the same cycle -> next cycle level=0, m_tvalid=0, beat_cnt=0; the offered beat is absent from the output.
- Async reset mid-frame (level=3) -> all outputs at reset values immediately; after release, a new 2-beat frame gives frame_len=2.
